// File: rtl/serial_sub.sv
// serial_sub -- bit-serial subtractor, LSB first, one bit per clock.
//
// Captures a and b on an accepted start, then runs a single full-subtractor
// cell against a borrow flip-flop for WIDTH cycles. The result is published
// together with a one-cycle done pulse. The outputs hold the last completed
// result until the next completion.
//
// Optional build macro: SERIAL_SUB_SIGNED_EN.
//   Defined:   ovf reports two's-complement overflow of a - b.
//   Undefined: ovf is tied to 0.
//
// Handshake (valid/ready):
//   start is a request that is honoured only while the block is idle or
//   showing done, which is while busy is low. While busy is high, start is
//   ignored, and a and b may change freely.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset; it has priority over start
//   start      request; accepted in IDLE or DONE
//   a, b       minuend / subtrahend, captured on an accepted start
//   busy       high while bits are being shifted
//   done       one-cycle pulse; diff/borrow/ovf were just updated
//   diff       a - b mod 2^WIDTH
//   borrow     1 iff a < b (unsigned)
//   ovf        signed overflow (0 unless SERIAL_SUB_SIGNED_EN)
//   state_dbg  current FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    // The lowest result bit would be shifted out before anyone reads it.
    // Only the upper WIDTH-1 bits are kept, and the full word is formed in
    // sr_next.
    logic [WIDTH-2:0] sr;
    logic             bff;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             bnext;
    logic [WIDTH-1:0] sr_next;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d       = sa[0] ^ sb[0] ^ bff;
        bnext   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bff);
        sr_next = {d, sr};
    end

`ifdef SERIAL_SUB_SIGNED_EN
    // The sign bits must be captured separately, because sa and sb are
    // shifted away during the operation.
    logic sgn_a;
    logic sgn_b;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            bff    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        bff   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_SIGNED_EN
                        sgn_a <= a[WIDTH-1];
                        sgn_b <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next[WIDTH-1:1];
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    bff <= bnext;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Publish the whole word at once, so that partial
                        // values are never visible.
                        diff   <= sr_next;
                        borrow <= bnext;
`ifdef SERIAL_SUB_SIGNED_EN
                        ovf    <= (sgn_a ^ sgn_b) & (d ^ sgn_a);
`endif
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SERIAL_SUB_SIGNED_EN
    assign ovf = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_sub.sv
// Directed testbench for serial_sub with WIDTH=8.
// Expected values are hand-computed constants.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic [1:0]   state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; sample and drive 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ovf is only expected to be nonzero in the signed build
  function automatic logic ovf_exp(input logic v);
`ifdef SERIAL_SUB_SIGNED_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Driver: a single start pulse, then check the latency and the result
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    int busy_bad;
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va;
    b = ~vb;
    n = 0;
    busy_bad = 0;
    while (!done && n < 20) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_busy_held"}, busy_bad, 0);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_borrow"}, borrow, eb);
    check({tag, "_ovf"}, ovf, ovf_exp(eo));
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, state_dbg, 2'd0);
    check({tag, "_hold_diff"}, diff, ed);
  endtask

  initial begin : stim
    int dcnt;
    int t;
    int t1;
    int t2;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic bo1;
    logic bo2;

    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_state", state_dbg, 2'd0);

    // reset_n has priority over start
    start = 1'b1;
    tick();
    check("rst_prio_busy", busy, 1'b0);
    start = 1'b0;
    reset_n = 1'b1;
    tick();

    run_op("5m3", 8'd5, 8'd3, 8'h02, 1'b0, 1'b0);
    run_op("3m5", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);
    run_op("0m0", 8'd0, 8'd0, 8'h00, 1'b0, 1'b0);
    run_op("80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("7Fm FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Start pulsed 3 cycles into SHIFT is ignored
    a = 8'h20;
    b = 8'h05;
    start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0;
    d1 = '0;
    bo1 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
      end
      if (i == 3) start = 1'b0;
      tick();
      if (done) begin
        dcnt++;
        d1 = diff;
        bo1 = borrow;
      end
    end
    check("ign_done_count", dcnt, 1);
    check("ign_diff", d1, 8'h1B);
    check("ign_borrow", bo1, 1'b0);

    // Reset during SHIFT aborts the operation
    a = 8'h55;
    b = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_pre_busy", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 8'h00);
    check("abort_borrow", borrow, 1'b0);
    check("abort_state", state_dbg, 2'd0);
    reset_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run_op("9m4", 8'd9, 8'd4, 8'h05, 1'b0, 1'b0);

    // Back-to-back with start held high
    a = 8'd10;
    b = 8'd1;
    start = 1'b1;
    tick();
    t = 0;
    t1 = -1;
    t2 = -1;
    d1 = '0;
    d2 = '0;
    bo1 = 1'b0;
    bo2 = 1'b0;
    while (t2 < 0 && t < 40) begin
      tick();
      t++;
      if (done) begin
        if (t1 < 0) begin
          t1 = t;
          d1 = diff;
          bo1 = borrow;
          a = 8'd1;
          b = 8'd2;
        end else begin
          t2 = t;
          d2 = diff;
          bo2 = borrow;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_latency", t1, W);
    check("b2b_period", t2 - t1, W + 1);
    check("b2b_diff1", d1, 8'h09);
    check("b2b_borrow1", bo1, 1'b0);
    check("b2b_diff2", d2, 8'hFF);
    check("b2b_borrow2", bo2, 1'b1);
    tick();
    check("b2b_end_done", done, 1'b0);
    check("b2b_end_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
